// File: rtl/spram_pkg.sv
// spram_pkg: shared types and helpers for the byte-enable scratch RAM
// with hardware clear engine.
package spram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } clr_state_e;

   // Widest word lane_merge can handle; callers zero-extend into it.
   localparam int MAX_W = 256;

   function automatic int nb_of(
      input int data_w,
      input int byte_w
   );
      return data_w / byte_w;
   endfunction

   function automatic logic [MAX_W-1:0] lane_merge(
      input logic [MAX_W-1:0] old_w,
      input logic [MAX_W-1:0] new_w,
      input logic [MAX_W-1:0] be,
      input int               byte_w
   );
      logic [MAX_W-1:0] res;
      res = old_w;
      for (int i = 0; i < MAX_W; i++) begin
         if (be[i / byte_w]) begin
            res[i] = new_w[i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/spram_clear_ctrl.sv
// spram_clear_ctrl: clear FSM that sweeps every word once after reset
// or on request, flagging the RAM busy while it runs.
module spram_clear_ctrl
   import spram_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         unique case (state_q)
            ST_CLEAR: begin
               if (cnt_q == LAST) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            ST_IDLE: begin
               if (clear_i) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign clr_we_o   = busy_q;
   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/spram_be_clr.sv
// spram_be_clr: single-port synchronous RAM with byte-lane writes,
// selectable read-during-write result, optional output register and clear engine.
module spram_be_clr
   import spram_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                BYTE_W    = 8,
   parameter int                ADDR_W    = 10,
   parameter int                DEPTH     = 1024,
   parameter int                OUT_REG   = 0,
   parameter int                RDW_MODE  = 0,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
   localparam int               NB        = nb_of(DATA_W, BYTE_W)
) (
   input  logic              in_clock,
   input  logic              in_reset_n,
   input  logic              in_enable,
   input  logic              in_write,
   input  logic [NB-1:0]     in_byte_en,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_clear,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_busy
);

   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
   localparam bit                RDW     = (RDW_MODE != 0);

   typedef struct packed {
      logic              vld;
      logic              wr;
      logic              inr;
      logic [NB-1:0]     be;
      logic [DATA_W-1:0] wd;
   } rd_stage_t;

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              acc;
   logic              in_rng;
   logic              wr_en;
   logic [IDX_W-1:0]  ram_idx;
   logic [IDX_W-1:0]  wr_idx;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;
   rd_stage_t         s1_q;
   rd_stage_t         s1_d;

   logic [DATA_W-1:0] res_d;
   logic              res_vld_d;
   logic [DATA_W-1:0] fin_data_d;
   logic              fin_vld_d;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;

   spram_clear_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr (
      .clk_i      (in_clock),
      .rst_ni     (in_reset_n),
      .clear_i    (in_clear),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // A clear request wins over a user access in the same cycle.
   always_comb begin
      in_rng   = ({1'b0, in_address} < DEPTH_A);
      acc      = !busy && in_enable && !in_clear;
      wr_en    = acc && in_write && in_rng;
      ram_idx  = busy ? clr_addr[IDX_W-1:0] : in_address[IDX_W-1:0];
      wr_idx   = in_address[IDX_W-1:0];
      s1_d     = '0;
      s1_d.vld = acc && (!in_write || (RDW && in_rng));
      s1_d.wr  = in_write;
      s1_d.inr = in_rng;
      s1_d.be  = in_byte_en;
      s1_d.wd  = in_data;
   end

   // Read-before-write port: rd_q holds the old word, merged later for RDW.
   always_ff @(posedge in_clock) begin
      if (clr_we) begin
         mem_q[clr_addr[IDX_W-1:0]] <= CLEAR_VAL;
      end else if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (in_byte_en[i]) begin
               mem_q[wr_idx][i*BYTE_W +: BYTE_W] <=
                  in_data[i*BYTE_W +: BYTE_W];
            end
         end
      end
      rd_q <= mem_q[ram_idx];
   end

   always_ff @(posedge in_clock) begin
      if (!in_reset_n) begin
         s1_q <= '0;
      end else begin
         s1_q <= s1_d;
      end
   end

   always_comb begin
      res_vld_d = s1_q.vld;
      res_d     = '0;
      unique case (1'b1)
         !s1_q.inr:
            res_d = '0;
         s1_q.inr && s1_q.wr:
            res_d = DATA_W'(lane_merge(MAX_W'(rd_q),
                                       MAX_W'(s1_q.wd),
                                       MAX_W'(s1_q.be),
                                       BYTE_W));
         default:
            res_d = rd_q;
      endcase
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] p_data_q;
         logic              p_vld_q;

         always_ff @(posedge in_clock) begin
            if (!in_reset_n) begin
               p_data_q <= '0;
               p_vld_q  <= 1'b0;
            end else begin
               p_data_q <= res_d;
               p_vld_q  <= res_vld_d;
            end
         end

         assign fin_data_d = p_data_q;
         assign fin_vld_d  = p_vld_q;
      end else begin : g_noreg
         assign fin_data_d = res_d;
         assign fin_vld_d  = res_vld_d;
      end
   endgenerate

   always_ff @(posedge in_clock) begin
      if (!in_reset_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= fin_vld_d;
         if (fin_vld_d) begin
            data_q <= fin_data_d;
         end
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_busy  = busy;

endmodule

// File: tb/tb_spram_be_clr.sv
// Bench for spram_be_clr: two instances (plain 1024-word, and registered
// write-first 1000-word) checked against reference memories via scoreboards.
`timescale 1ns/1ps
module tb_spram_be_clr;

   localparam int DEPTH0 = 1024;
   localparam int DEPTH1 = 1000;
   localparam logic [15:0] CV1 = 16'hC3C3;

   logic        clk = 1'b0;
   logic        rst_n, en, wr, clr;
   logic [1:0]  be;
   logic [9:0]  addr;
   logic [15:0] din;
   logic [15:0] d0, d1;
   logic        v0, v1, b0, b1;

   always #5 clk = ~clk;

   spram_be_clr #(
      .OUT_REG (0), .RDW_MODE (0), .DEPTH (DEPTH0)
   ) dut0 (
      .in_clock (clk), .in_reset_n (rst_n), .in_enable (en),
      .in_write (wr), .in_byte_en (be), .in_address (addr),
      .in_data (din), .in_clear (clr), .out_data (d0),
      .out_valid (v0), .out_busy (b0)
   );

   spram_be_clr #(
      .OUT_REG (1), .RDW_MODE (1), .DEPTH (DEPTH1), .CLEAR_VAL (CV1)
   ) dut1 (
      .in_clock (clk), .in_reset_n (rst_n), .in_enable (en),
      .in_write (wr), .in_byte_en (be), .in_address (addr),
      .in_data (din), .in_clear (clr), .out_data (d1),
      .out_valid (v1), .out_busy (b1)
   );

   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] m0 [DEPTH0];
   logic [15:0] m1 [DEPTH1];
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_pass = 0;
   bit          mon_on = 1'b0;

   always @(posedge clk) cyc++;

   // Scoreboards: each out_valid pops the oldest expectation, incl. its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
         while (q0.size() > 0 && q0[0].c < cyc) begin
            e = q0.pop_front();
            n_chk++;
            $display("FAIL sb0_missing: no valid at cycle %0d, required %h", e.c, e.d);
         end
         while (q1.size() > 0 && q1[0].c < cyc) begin
            e = q1.pop_front();
            n_chk++;
            $display("FAIL sb1_missing: no valid at cycle %0d, required %h", e.c, e.d);
         end
         if (v0) begin
            n_chk++;
            if (q0.size() == 0) begin
               $display("FAIL sb0_extra: got valid data=%h, required no valid", d0);
            end else begin
               e = q0.pop_front();
               if (d0 !== e.d || cyc != e.c)
                  $display("FAIL sb0_data: got %h @%0d, required %h @%0d", d0, cyc, e.d, e.c);
               else
                  n_pass++;
            end
         end
         if (v1) begin
            n_chk++;
            if (q1.size() == 0) begin
               $display("FAIL sb1_extra: got valid data=%h, required no valid", d1);
            end else begin
               e = q1.pop_front();
               if (d1 !== e.d || cyc != e.c)
                  $display("FAIL sb1_data: got %h @%0d, required %h @%0d", d1, cyc, e.d, e.c);
               else
                  n_pass++;
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic issue(
      input logic       e_i,
      input logic       w_i,
      input logic [1:0] be_i,
      input logic [9:0] a_i,
      input logic [15:0] d_i,
      input logic       c_i,
      input bit         acc
   );
      @(negedge clk);
      en = e_i; wr = w_i; be = be_i; addr = a_i; din = d_i; clr = c_i;
      if (acc && e_i && !c_i) begin
         if (!w_i) begin
            q0.push_back('{d: m0[a_i], c: cyc + 2});
         end else begin
            for (int l = 0; l < 2; l++)
               if (be_i[l]) m0[a_i][l*8 +: 8] = d_i[l*8 +: 8];
         end
         if (int'(a_i) < DEPTH1) begin
            if (w_i) begin
               for (int l = 0; l < 2; l++)
                  if (be_i[l]) m1[a_i][l*8 +: 8] = d_i[l*8 +: 8];
            end
            q1.push_back('{d: m1[a_i], c: cyc + 3});
         end else if (!w_i) begin
            q1.push_back('{d: 16'h0000, c: cyc + 3});
         end
      end
   endtask

   task automatic idle();
      @(negedge clk);
      en = 1'b0; wr = 1'b0; clr = 1'b0; be = 2'b00;
   endtask

   task automatic drain();
      repeat (6) @(negedge clk);
   endtask

   task automatic count_busy(output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 4000; i++) begin
         if (!b0 && !b1) break;
         if (b0) c0++;
         if (b1) c1++;
         @(negedge clk);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH0; i++) m0[i] = 16'h0000;
      for (int i = 0; i < DEPTH1; i++) m1[i] = CV1;
   endtask

   task automatic test_reset();
      int c0, c1;
      rst_n = 1'b0; en = 1'b0; wr = 1'b0; clr = 1'b0;
      be = 2'b00; addr = '0; din = '0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (v0 !== 1'b0 || d0 !== 16'h0 || b0 !== 1'b1)
         $display("FAIL reset0: got v=%b d=%h b=%b, required 0 0000 1", v0, d0, b0);
      else n_pass++;
      n_chk++;
      if (v1 !== 1'b0 || d1 !== 16'h0 || b1 !== 1'b1)
         $display("FAIL reset1: got v=%b d=%h b=%b, required 0 0000 1", v1, d1, b1);
      else n_pass++;
      rst_n = 1'b1;
      count_busy(c0, c1);
      n_chk++;
      if (c0 != 1024) $display("FAIL busy_len0: got %0d, required 1024", c0);
      else n_pass++;
      n_chk++;
      if (c1 != 1000) $display("FAIL busy_len1: got %0d, required 1000", c1);
      else n_pass++;
      model_clear();
      mon_on = 1'b1;
   endtask

   task automatic test_read_cleared();
      issue(1, 0, 2'b00, 10'd0,    16'h0, 0, 1);
      issue(1, 0, 2'b00, 10'd3,    16'h0, 0, 1);
      issue(1, 0, 2'b00, 10'd999,  16'h0, 0, 1);
      issue(1, 0, 2'b00, 10'd1023, 16'h0, 0, 1);
      idle();
      drain();
      n_chk++;
      if (d0 !== 16'h0000) $display("FAIL cleared0: got %h, required 0000", d0);
      else n_pass++;
   endtask

   task automatic test_write_read();
      issue(1, 1, 2'b11, 10'd3, 16'hA5A5, 0, 1);
      issue(1, 0, 2'b00, 10'd3, 16'h0,    0, 1);
      idle();
      drain();
      n_chk++;
      if (d0 !== 16'hA5A5 || d1 !== 16'hA5A5)
         $display("FAIL wr_rd: got %h/%h, required a5a5/a5a5", d0, d1);
      else n_pass++;
   endtask

   task automatic test_byte_lanes();
      issue(1, 1, 2'b11, 10'd5, 16'h1234, 0, 1);
      issue(1, 1, 2'b10, 10'd5, 16'hFFFF, 0, 1);
      issue(1, 0, 2'b00, 10'd5, 16'h0,    0, 1);
      issue(1, 1, 2'b00, 10'd5, 16'h0000, 0, 1);
      issue(1, 0, 2'b00, 10'd5, 16'h0,    0, 1);
      idle();
      drain();
      n_chk++;
      if (d0 !== 16'hFF34 || d1 !== 16'hFF34)
         $display("FAIL lanes: got %h/%h, required ff34/ff34", d0, d1);
      else n_pass++;
   endtask

   task automatic test_rdw();
      issue(1, 1, 2'b11, 10'd7, 16'h1200, 0, 1);
      issue(1, 1, 2'b01, 10'd7, 16'hBEEF, 0, 1);
      idle();
      drain();
      n_chk++;
      if (d1 !== 16'h12EF) $display("FAIL rdw1: got %h, required 12ef", d1);
      else n_pass++;
      n_chk++;
      if (d0 !== 16'hFF34) $display("FAIL rdw0_hold: got %h, required ff34", d0);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      issue(1, 1, 2'b11, 10'd1010, 16'h5555, 0, 1);
      issue(1, 0, 2'b00, 10'd1010, 16'h0,    0, 1);
      issue(1, 1, 2'b11, 10'd999,  16'h9999, 0, 1);
      issue(1, 0, 2'b00, 10'd999,  16'h0,    0, 1);
      issue(1, 0, 2'b00, 10'd1023, 16'h0,    0, 1);
      idle();
      drain();
      n_chk++;
      if (q0.size() != 0 || q1.size() != 0)
         $display("FAIL oor_drain: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] w;
      for (int i = 0; i < 12; i++) begin
         w = 16'($urandom);
         issue(1, 1, 2'(1 + (i % 3)), 10'(100 + i), w, 0, 1);
         issue(1, 0, 2'b00, 10'(100 + i), 16'h0, 0, 1);
      end
      for (int i = 0; i < 12; i++)
         issue(1, 0, 2'b00, 10'(111 - i), 16'h0, 0, 1);
      idle();
      drain();
      n_chk++;
      if (q0.size() != 0 || q1.size() != 0)
         $display("FAIL b2b_drain: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
      else n_pass++;
   endtask

   task automatic test_clear();
      int c0, c1;
      issue(1, 0, 2'b00, 10'd5, 16'h0, 0, 1);
      issue(1, 0, 2'b00, 10'd5, 16'h0, 1, 0);
      issue(1, 0, 2'b00, 10'd3, 16'h0, 0, 0);
      issue(1, 1, 2'b11, 10'd3, 16'h7777, 1, 0);
      issue(1, 0, 2'b00, 10'd3, 16'h0, 0, 0);
      idle();
      count_busy(c0, c1);
      n_chk++;
      if (c0 != 1021) $display("FAIL clr_len0: got %0d, required 1021", c0);
      else n_pass++;
      n_chk++;
      if (c1 != 997) $display("FAIL clr_len1: got %0d, required 997", c1);
      else n_pass++;
      model_clear();
      issue(1, 0, 2'b00, 10'd5, 16'h0, 0, 1);
      issue(1, 0, 2'b00, 10'd3, 16'h0, 0, 1);
      idle();
      drain();
      n_chk++;
      if (d0 !== 16'h0000 || d1 !== CV1)
         $display("FAIL clr_val: got %h/%h, required 0000/%h", d0, d1, CV1);
      else n_pass++;
   endtask

   task automatic test_reset_mid_clear();
      int c0, c1;
      issue(1, 1, 2'b11, 10'd9, 16'h4242, 0, 1);
      issue(0, 0, 2'b00, 10'd0, 16'h0, 1, 0);
      idle();
      repeat (499) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (b0 !== 1'b1 || v0 !== 1'b0 || d0 !== 16'h0)
         $display("FAIL midrst: got b=%b v=%b d=%h, required 1 0 0000", b0, v0, d0);
      else n_pass++;
      rst_n = 1'b1;
      count_busy(c0, c1);
      n_chk++;
      if (c0 != 1024 || c1 != 1000)
         $display("FAIL midrst_len: got %0d/%0d, required 1024/1000", c0, c1);
      else n_pass++;
      model_clear();
      issue(1, 0, 2'b00, 10'd9, 16'h0, 0, 1);
      issue(1, 0, 2'b00, 10'd3, 16'h0, 0, 1);
      idle();
      drain();
      n_chk++;
      if (q0.size() != 0 || q1.size() != 0)
         $display("FAIL final_drain: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read_cleared();
      test_write_read();
      test_byte_lanes();
      test_rdw();
      test_out_of_range();
      test_back_to_back();
      test_clear();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
